// File: rtl/lut_cfg_loader.sv
// Serial configuration loader: hunts for a sync word, shifts N_LUT 8-bit LUT masks into a shadow
// register and commits them atomically. Define LUT_CFG_PARITY_EN to expect an even-parity bit after each mask.
module lut_cfg_loader #(
    parameter int          N_LUT        = 4,
    parameter logic [7:0]  SYNC_WORD    = 8'hA5,
    parameter int          SYNC_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_valid,
    input  logic               cfg_data,
    output logic               cfg_ready,
    output logic               cfg_busy,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic [N_LUT*8-1:0] lut_mask
);

    localparam int LW = (N_LUT > 1) ? $clog2(N_LUT) : 1;
    localparam int SW = $clog2(SYNC_TIMEOUT + 1);
`ifdef LUT_CFG_PARITY_EN
    localparam logic [3:0] LAST_BIT = 4'd8;  // bit 8 of each group is the parity bit
`else
    localparam logic [3:0] LAST_BIT = 4'd7;
`endif

    typedef enum logic [2:0] {IDLE, SYNC, LOAD, COMMIT, ERROR} state_t;

    state_t               state, next_state;
    logic [7:0]           window, win_next;
    logic [SW-1:0]        sync_cnt;
    logic [3:0]           bit_cnt;
    logic [LW-1:0]        lut_idx;
    logic [N_LUT*8-1:0]   shadow;
    logic                 restart, take, last_lut;
`ifdef LUT_CFG_PARITY_EN
    logic [7:0]           cur_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        take       = 1'b0;
        win_next   = {window[6:0], cfg_data};
        last_lut   = (lut_idx == LW'(N_LUT - 1));
        cfg_ready  = (state == SYNC) || (state == LOAD);
        cfg_busy   = cfg_ready;
        cfg_done   = (state == COMMIT);
`ifdef LUT_CFG_PARITY_EN
        cur_byte   = 8'h00;
        for (int i = 0; i < N_LUT; i++)
            if (lut_idx == LW'(i)) cur_byte = shadow[i*8 +: 8];
`endif
        case (state)
            IDLE, ERROR: begin
                if (cfg_start) begin
                    restart    = 1'b1;
                    next_state = SYNC;
                end
            end
            SYNC, LOAD: begin
                // A start wins over a bit offered in the same cycle; that bit is dropped.
                if (cfg_start) begin
                    restart    = 1'b1;
                    next_state = SYNC;
                end else if (cfg_valid) begin
                    take = 1'b1;
                    if (state == SYNC) begin
                        if (win_next == SYNC_WORD)                 next_state = LOAD;
                        else if (sync_cnt == SW'(SYNC_TIMEOUT - 1)) next_state = ERROR;
                    end else if (bit_cnt == LAST_BIT) begin
`ifdef LUT_CFG_PARITY_EN
                        if ((^cur_byte) ^ cfg_data) next_state = ERROR;
                        else
`endif
                        if (last_lut) next_state = COMMIT;
                    end
                end
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the shadow is a handful of flops, so it is reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window   <= '0;
            sync_cnt <= '0;
            bit_cnt  <= '0;
            lut_idx  <= '0;
            shadow   <= '0;
            lut_mask <= '0;
            cfg_err  <= 1'b0;
        end else begin
            if (restart) begin
                window   <= '0;
                sync_cnt <= '0;
                bit_cnt  <= '0;
                lut_idx  <= '0;
                shadow   <= '0;
                cfg_err  <= 1'b0;
            end else if (take) begin
                if (state == SYNC) begin
                    window   <= win_next;
                    sync_cnt <= sync_cnt + 1'b1;
                end else if (state == LOAD) begin
                    for (int i = 0; i < N_LUT; i++)
                        for (int k = 0; k < 8; k++)
                            if (lut_idx == LW'(i) && bit_cnt == 4'(k)) shadow[i*8 + k] <= cfg_data;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        lut_idx <= lut_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
            if (next_state == ERROR && state != ERROR) cfg_err <= 1'b1;
            if (state == COMMIT) lut_mask <= shadow;
        end
    end

endmodule

// File: doc/lut_cfg_loader.md
LUT_CFG_LOADER -- requirements
Module: lut_cfg_loader

Interface
REQ-001 SHALL have parameter N_LUT, default 4, meaning number of 3-input LUTs configured (8-bit mask each).
REQ-002 SHALL have parameter SYNC_WORD, default 8'hA5, meaning bitstream sync pattern preceding mask data.
REQ-003 SHALL have parameter SYNC_TIMEOUT, default 64, meaning max accepted bits in SYNC before error.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-005 SHALL have clk  input  1  rising-edge clock.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have cfg_start  input  1  single-cycle request to begin (or restart) a load.
REQ-008 SHALL have cfg_valid  input  1  cfg_data is valid this cycle.
REQ-009 SHALL have cfg_data  input  1  serial bitstream bit.
REQ-010 SHALL have cfg_ready  output  1  loader accepts a bit this cycle; a bit is accepted when cfg_valid & cfg_ready.
REQ-011 SHALL have cfg_busy  output  1  high in SYNC and LOAD.
REQ-012 SHALL have cfg_done  output  1  one-cycle pulse on successful commit.
REQ-013 SHALL have cfg_err  output  1  sticky error flag.
REQ-014 SHALL have lut_mask  output  N_LUT*8  committed masks; LUT i occupies bits [8i+7:8i].

Function
REQ-015 SHALL implement states IDLE, SYNC, LOAD, COMMIT, ERROR; cfg_ready=1 only in SYNC and LOAD.
REQ-016 IDLE: cfg_start -> SYNC next cycle; clears sync window, bit/LUT counters, shadow masks and cfg_err.
REQ-017 SYNC: each accepted bit shifts window = {window[6:0], cfg_data}; when updated window == SYNC_WORD -> LOAD next cycle.
REQ-018 SYNC: if SYNC_TIMEOUT bits accepted without match -> ERROR.
REQ-019 LOAD: accepted bits fill shadow mask LSB first, LUT 0 first (bit k of LUT i = (8i+k)th data bit).
REQ-020 LOAD: after last bit of LUT N_LUT-1 is accepted -> COMMIT next cycle.
REQ-021 COMMIT: lut_mask <= shadow in one cycle, cfg_done=1 that cycle, -> IDLE; lut_mask visible the cycle after COMMIT.
REQ-022 ERROR: cfg_err=1, lut_mask unchanged; remains until cfg_start, which -> SYNC.
REQ-023 cfg_start in SYNC or LOAD SHALL abort, discard shadow, and restart at SYNC; lut_mask unchanged; cfg_start with simultaneous accepted bit: bit is discarded.
REQ-024 cfg_start in COMMIT SHALL be ignored; commit completes.
REQ-025 cfg_valid while cfg_ready=0 SHALL be ignored; stalls (cfg_valid=0) hold all state.
REQ-026 lut_mask SHALL change only in COMMIT; never partially updated.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, lut_mask=0, shadow=0, counters=0, cfg_ready=0, cfg_busy=0, cfg_done=0, cfg_err=0.
REQ-028 Reset mid-load SHALL discard the load; after release the block waits in IDLE for cfg_start.

Configuration
REQ-029 Macro LUT_CFG_PARITY_EN defined: each 8-bit mask in LOAD SHALL be followed by one parity bit; even parity (XOR of 8 mask bits ^ parity bit == 0) required; mismatch -> ERROR next cycle, lut_mask unchanged.
REQ-030 LUT_CFG_PARITY_EN undefined: no parity bits; LOAD consumes exactly N_LUT*8 bits.

Verification
REQ-031 N_LUT=2, no parity: start, bits 10100101 then 0x96 and 0xE8 LSB first, valid every cycle -> cfg_done one cycle after 24th accepted bit; lut_mask=16'hE896.
REQ-032 Prefix 1,1,0 before 10100101 and same data -> sync locks on A5, lut_mask=16'hE896.
REQ-033 start then 64 zeros -> cfg_err=1, cfg_busy=0, lut_mask keeps prior value; next cfg_start clears cfg_err.
REQ-034 cfg_start after 5 data bits of a load, then full valid stream for 0x3C,0x0F -> lut_mask=16'h0F3C, single cfg_done.
REQ-035 LUT_CFG_PARITY_EN: mask 0x96 with parity 1 -> cfg_err=1, lut_mask unchanged; with parity 0 -> accepted.
REQ-036 rst_n low during LOAD after prior commit of 16'hE896 -> lut_mask=0 immediately, IDLE, cfg_ready=0.
